// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types, default sizes and helpers for the multi-port
//               register file (regfile_mp and regfile_rd_port).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Init engine walks the array in RF_INIT, then serves accesses in RF_RUN.
    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;

    // Ceiling log2, usable in parameter expressions; returns 0 for value<=1.
    function automatic int rf_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_port
// Description : One combinational read port of regfile_mp. Selects between the
//               stored array word and any same-cycle write to the same
//               address (highest write port wins), then forces zero for
//               register 0 when ZERO_REG is set.
// Ports       : raddr_i  - read address
//               word_i   - array word at raddr_i (already 0 while not running)
//               waddr_i  - packed write addresses, port j at [j*ADDR_W +: ADDR_W]
//               wdata_i  - packed write data, port j at [j*DATA_W +: DATA_W]
//               wvalid_i - per-port write valid (already qualified by RUN)
//               rdata_o  - read data
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = 5,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]        raddr_i,
    input  logic [DATA_W-1:0]        word_i,
    input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
    input  logic [NUM_WR*DATA_W-1:0] wdata_i,
    input  logic [NUM_WR-1:0]        wvalid_i,
    output logic [DATA_W-1:0]        rdata_o
);

    always_comb begin
        rdata_o = word_i;
        // Later iterations overwrite earlier ones, so the highest matching
        // write port provides the forwarded value.
        for (int j = 0; j < NUM_WR; j++) begin
            if (wvalid_i[j] && (waddr_i[j*ADDR_W +: ADDR_W] == raddr_i)) begin
                rdata_o = wdata_i[j*DATA_W +: DATA_W];
            end
        end
        // The zero register wins even over a forwarded write.
        if ((ZERO_REG != 0) && (raddr_i == '0)) begin
            rdata_o = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port register file with clocked writes,
//               combinational reads with write-to-read bypass, optional
//               hardwired-zero register 0 and a sequential clear engine that
//               zeroes the array after every reset.
// Ports       : clk_i     - clock, rising edge
//               rst_i     - synchronous active-high reset
//               raddr_i   - packed read addresses (NUM_RD x ADDR_W)
//               rdata_o   - packed read data (NUM_RD x DATA_W)
//               we_i      - write enable per write port
//               waddr_i   - packed write addresses (NUM_WR x ADDR_W)
//               wdata_i   - packed write data (NUM_WR x DATA_W)
//               ready_o   - registered, high once the array has been cleared
//               wr_drop_o - registered, pulses after a discarded write
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = rf_clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    input  logic [NUM_WR-1:0]        we_i,
    input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
    input  logic [NUM_WR*DATA_W-1:0] wdata_i,
    output logic                     ready_o,
    output logic                     wr_drop_o
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_t          state_q,   state_d;
    logic [ADDR_W-1:0]  cnt_q,     cnt_d;
    logic               ready_q,   ready_d;
    logic               wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               w_run;
    logic [NUM_WR-1:0]  w_run_we;   // write requests seen while running
    logic [NUM_WR-1:0]  w_wr_en;    // writes that actually update the array
    logic               w_conflict;
    logic [DATA_W-1:0]  w_word [NUM_RD];

    assign w_run    = (state_q == RF_RUN);
    assign w_run_we = we_i & {NUM_WR{w_run}};

    // Writes to register 0 with ZERO_REG set are dropped silently and do not
    // take part in conflict detection.
    always_comb begin
        w_wr_en = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            w_wr_en[j] = w_run_we[j] &&
                         !((ZERO_REG != 0) && (waddr_i[j*ADDR_W +: ADDR_W] == '0));
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (w_wr_en[i] && w_wr_en[j] &&
                    (waddr_i[i*ADDR_W +: ADDR_W] == waddr_i[j*ADDR_W +: ADDR_W])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Init / run controller
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        wr_drop_d = 1'b0;
        case (state_q)
            RF_INIT: begin
                cnt_d     = cnt_q + 1'b1;
                wr_drop_d = |we_i;
                if (cnt_q == C_LAST_ADDR) begin
                    state_d = RF_RUN;
                    ready_d = 1'b1;
                end
            end
            RF_RUN: begin
                wr_drop_d = w_conflict;
            end
            default: begin
                state_d = RF_INIT;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RF_INIT;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Array: cleared one entry per cycle during init, written in run.
    // The reset cycle itself leaves the contents untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == RF_INIT) begin
                mem_q[cnt_q] <= '0;
            end else begin
                // Ascending port order: the highest port wins on a conflict.
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_wr_en[j]) begin
                        mem_q[waddr_i[j*ADDR_W +: ADDR_W]] <= wdata_i[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            // Reads return 0 until the clear engine has finished.
            assign w_word[k] = w_run ? mem_q[raddr_i[k*ADDR_W +: ADDR_W]] : '0;

            regfile_rd_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .NUM_WR   (NUM_WR),
                .ZERO_REG (ZERO_REG)
            ) u_rd_port (
                .raddr_i  (raddr_i[k*ADDR_W +: ADDR_W]),
                .word_i   (w_word[k]),
                .waddr_i  (waddr_i),
                .wdata_i  (wdata_i),
                .wvalid_i (w_run_we),
                .rdata_o  (rdata_o[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign ready_o   = ready_q;
    assign wr_drop_o = wr_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp. Two instances run in
//               lockstep: A (32x32, 2 read, 2 write, zero reg) and
//               B (16x64, 3 read, 1 write, no zero reg), each compared every
//               cycle against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- instance A ----------------
    logic        rst_a;
    logic [9:0]  raddr_a;
    logic [63:0] rdata_a;
    logic [1:0]  we_a;
    logic [9:0]  waddr_a;
    logic [63:0] wdata_a;
    logic        ready_a, drop_a;

    regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .raddr_i(raddr_a), .rdata_o(rdata_a),
        .we_i(we_a), .waddr_i(waddr_a), .wdata_i(wdata_a),
        .ready_o(ready_a), .wr_drop_o(drop_a)
    );

    // ---------------- instance B ----------------
    logic         rst_b;
    logic [11:0]  raddr_b;
    logic [191:0] rdata_b;
    logic [0:0]   we_b;
    logic [3:0]   waddr_b;
    logic [63:0]  wdata_b;
    logic         ready_b, drop_b;

    regfile_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(3), .NUM_WR(1), .ZERO_REG(0)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .raddr_i(raddr_b), .rdata_o(rdata_b),
        .we_i(we_b), .waddr_i(waddr_b), .wdata_i(wdata_b),
        .ready_o(ready_b), .wr_drop_o(drop_b)
    );

    // ---------------- reference models ----------------
    logic [31:0] m_a [32];
    bit          init_a, rdy_a, mdrop_a;
    int          cnt_a;
    logic [63:0] m_b [16];
    bit          init_b, rdy_b, mdrop_b;
    int          cnt_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected read value: 0 until cleared, else stored value overridden by a
    // same-cycle write (highest port last), register 0 forced to zero.
    function automatic logic [31:0] exp_a(input int k);
        logic [4:0]  ra;
        logic [31:0] v;
        ra = raddr_a[k*5 +: 5];
        if (!rdy_a) return '0;
        v = m_a[ra];
        for (int j = 0; j < 2; j++)
            if (we_a[j] && waddr_a[j*5 +: 5] == ra) v = wdata_a[j*32 +: 32];
        if (ra == 5'd0) v = '0;
        return v;
    endfunction

    function automatic logic [63:0] exp_b(input int k);
        logic [3:0]  ra;
        logic [63:0] v;
        ra = raddr_b[k*4 +: 4];
        if (!rdy_b) return '0;
        v = m_b[ra];
        if (we_b[0] && waddr_b == ra) v = wdata_b;
        return v;
    endfunction

    function automatic void upd_a();
        logic [4:0] wa0, wa1;
        wa0 = waddr_a[4:0];
        wa1 = waddr_a[9:5];
        if (rst_a) begin
            init_a = 1; cnt_a = 0; rdy_a = 0; mdrop_a = 0;
        end else if (init_a) begin
            mdrop_a = |we_a;
            cnt_a++;
            if (cnt_a == 32) begin
                init_a = 0; rdy_a = 1;
                foreach (m_a[i]) m_a[i] = '0;
            end
        end else begin
            mdrop_a = we_a[0] && we_a[1] && (wa0 == wa1) && (wa0 != 5'd0);
            if (we_a[0] && wa0 != 5'd0) m_a[wa0] = wdata_a[31:0];
            if (we_a[1] && wa1 != 5'd0) m_a[wa1] = wdata_a[63:32];
        end
    endfunction

    function automatic void upd_b();
        if (rst_b) begin
            init_b = 1; cnt_b = 0; rdy_b = 0; mdrop_b = 0;
        end else if (init_b) begin
            mdrop_b = we_b[0];
            cnt_b++;
            if (cnt_b == 16) begin
                init_b = 0; rdy_b = 1;
                foreach (m_b[i]) m_b[i] = '0;
            end
        end else begin
            mdrop_b = 0;
            if (we_b[0]) m_b[waddr_b] = wdata_b;
        end
    endfunction

    // Check all outputs mid-cycle, then advance one clock and the models.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("a_rd%0d", k), 64'(rdata_a[k*32 +: 32]), 64'(exp_a(k)));
        chk("a_ready", 64'(ready_a), 64'(rdy_a));
        chk("a_drop",  64'(drop_a),  64'(mdrop_a));
        for (int k = 0; k < 3; k++)
            chk($sformatf("b_rd%0d", k), rdata_b[k*64 +: 64], exp_b(k));
        chk("b_ready", 64'(ready_b), 64'(rdy_b));
        chk("b_drop",  64'(drop_b),  64'(mdrop_b));
        @(posedge clk);
        upd_a();
        upd_b();
        #1;
    endtask

    task automatic drv_a(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        we_a    = we;
        waddr_a = {wa1, wa0};
        wdata_a = {wd1, wd0};
        raddr_a = {ra1, ra0};
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        drv_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0);
        we_b = 1'b0; waddr_b = '0; wdata_b = '0; raddr_b = '0;
        @(posedge clk);
        upd_a();
        upd_b();
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Init with write enables held high: drops flagged, writes ignored.
        for (int i = 0; i < 32; i++) begin
            drv_a(2'b01, 5'(i), $urandom, 5'd0, 32'd0, 5'(i), 5'd1);
            if (i == 15) begin #2; chk("b_ready_before_16", 64'(ready_b), 64'd0); end
            if (i == 16) begin #2; chk("b_ready_at_16",     64'(ready_b), 64'd1); end
            if (i == 31) begin #2; chk("a_ready_before_32", 64'(ready_a), 64'd0); end
            step();
        end
        #2; chk("a_ready_at_32", 64'(ready_a), 64'd1);
        for (int i = 0; i < 16; i++) begin
            drv_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'(2*i), 5'(2*i+1));
            step();
        end

        // Write then read on both ports; write to r0 ignored without a drop.
        drv_a(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 5'd0, 5'd0); step();
        drv_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 5'd5);
        #2; chk("r5_p0", 64'(rdata_a[31:0]), 64'h0DEADBEEF);
        chk("r5_p1", 64'(rdata_a[63:32]), 64'h0DEADBEEF);
        step();
        drv_a(2'b01, 5'd0, 32'h1234, 5'd0, 32'd0, 5'd0, 5'd0); step();
        drv_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0);
        #2; chk("r0_zero", 64'(rdata_a[31:0]), 64'd0);
        chk("r0_no_drop", 64'(drop_a), 64'd0);
        step();

        // Same-cycle bypass.
        drv_a(2'b01, 5'd7, 32'h11, 5'd0, 32'd0, 5'd0, 5'd0); step();
        drv_a(2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'd0, 5'd0, 5'd7);
        #2; chk("bypass_r7", 64'(rdata_a[63:32]), 64'hA5A5A5A5);
        step();
        drv_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd7);
        #2; chk("stored_r7", 64'(rdata_a[31:0]), 64'hA5A5A5A5);
        step();

        // Two write ports colliding on r9: port 1 wins, drop flagged.
        drv_a(2'b11, 5'd9, 32'h1, 5'd9, 32'h2, 5'd9, 5'd9);
        #2; chk("conflict_bypass", 64'(rdata_a[31:0]), 64'h2);
        step();
        drv_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd9);
        #2; chk("conflict_r9", 64'(rdata_a[31:0]), 64'h2);
        chk("conflict_drop", 64'(drop_a), 64'd1);
        step();

        // Reset mid-init restarts the count.
        rst_a = 1'b1; step(); rst_a = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_a = 1'b1; step(); rst_a = 1'b0;
        for (int i = 0; i < 31; i++) step();
        #2; chk("rst_mid_ready_low", 64'(ready_a), 64'd0);
        step();
        #2; chk("rst_mid_ready_high", 64'(ready_a), 64'd1);

        // Reset in run re-clears the array.
        drv_a(2'b01, 5'd3, 32'h55, 5'd0, 32'd0, 5'd0, 5'd0); step();
        drv_a(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd3);
        rst_a = 1'b1; step(); rst_a = 1'b0;
        for (int i = 0; i < 32; i++) step();
        #2; chk("r3_cleared", 64'(rdata_a[31:0]), 64'd0);
        chk("r3_ready", 64'(ready_a), 64'd1);
        step();

        // Instance B: r0 is an ordinary register.
        we_b = 1'b1; waddr_b = 4'd0; wdata_b = 64'hFFFF_0000_FFFF_0000; raddr_b = {4'd3, 4'd2, 4'd1};
        step();
        we_b = 1'b0; raddr_b = '0;
        #2;
        for (int k = 0; k < 3; k++)
            chk($sformatf("b_r0_p%0d", k), rdata_b[k*64 +: 64], 64'hFFFF_0000_FFFF_0000);
        step();

        // Randomised traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            rst_a = ($urandom_range(0, 149) == 0);
            drv_a(2'($urandom), 5'($urandom), $urandom, 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom));
            // Keep both ports off r0 at once so only documented cases occur.
            if (we_a == 2'b11 && waddr_a == 10'd0) we_a = 2'b01;
            we_b    = 1'($urandom);
            waddr_b = 4'($urandom);
            wdata_b = {$urandom, $urandom};
            raddr_b = 12'($urandom);
            step();
        end
        rst_a = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
